// File: rtl/mult16_seq_pkg.sv
// Shared ALU definitions used by the sequential multiplier: FSM state type and
// datapath sizing constants.
package mult16_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_W     = 16;
    localparam int MUL_STEPS = 16;
    localparam int CNT_W     = $clog2(MUL_STEPS);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

endpackage

// File: rtl/mult16_seq_cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups with a
// second lookahead level producing the group carries and block pg/gg.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        pg,
    output logic        gg
);

    logic [15:0] p_bit;
    logic [15:0] g_bit;
    logic [15:0] carry;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_c;

    assign p_bit = a ^ b;
    assign g_bit = a & b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:0] gp;
        logic [3:0] gg4;
        logic       ci;

        assign gp  = p_bit[4*k +: 4];
        assign gg4 = g_bit[4*k +: 4];
        assign ci  = grp_c[k];

        assign carry[4*k]     = ci;
        assign carry[4*k + 1] = gg4[0] | (gp[0] & ci);
        assign carry[4*k + 2] = gg4[1] | (gp[1] & gg4[0]) | (gp[1] & gp[0] & ci);
        assign carry[4*k + 3] = gg4[2] | (gp[2] & gg4[1]) | (gp[2] & gp[1] & gg4[0])
                              | (gp[2] & gp[1] & gp[0] & ci);

        assign grp_p[k] = &gp;
        assign grp_g[k] = gg4[3] | (gp[3] & gg4[2]) | (gp[3] & gp[2] & gg4[1])
                        | (gp[3] & gp[2] & gp[1] & gg4[0]);
    end

    // Second lookahead level: group carries are flat sums of products, not a ripple.
    assign grp_c[0] = c_in;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & c_in);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);

    assign gg = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    assign pg = &grp_p;

    assign c_out = gg | (pg & c_in);
    assign sum   = p_bit ^ carry;

endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier: one accumulate step per clock
// through cla16, start/ready handshake, 32-bit registered product.
module mult16_seq
    import mult16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] p,
    output logic        ovf
);

    mul_state_t       state_q, state_d;
    logic [MUL_W-1:0] mcand_q, mcand_d;
    logic [MUL_W-1:0] mq_q, mq_d;
    logic [MUL_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      p_q, p_d;
    logic             ovf_q, ovf_d;

    logic             load;
    logic             last_step;
    logic [MUL_W-1:0] addend;
    logic [MUL_W-1:0] sum;
    logic             c_out;
    logic [31:0]      stepped;
    logic             unused_pg;
    logic             unused_gg;

    assign load      = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign last_step = (cnt_q == LAST_STEP);
    assign addend    = mq_q[0] ? mcand_q : '0;

    cla16 u_cla16 (
        .a     (acc_q),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out),
        .pg    (unused_pg),
        .gg    (unused_gg)
    );

    // Carry-out becomes the new top bit of acc; sum[0] shifts down into mq.
    assign stepped = {c_out, sum, mq_q[MUL_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d = mcand_q;
        mq_d    = mq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        if (load) begin
            mcand_d = a;
            mq_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            {acc_d, mq_d} = stepped;
            // cnt saturates at the last step; only a new load returns it to 0.
            if (!last_step) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                p_d   = stepped;
                ovf_d = |stepped[31:16];
            end
        end
    end

    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    assign p   = p_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: stimulus pushes hand-computed products,
// a negedge monitor pops and compares them whenever done pulses.
module tb_mult16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] p;
    logic        ovf;

    typedef struct {
        logic [31:0] p;
        logic        ovf;
        int          accept;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cycle    = 0;
    int   busy_len = 0;

    mult16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Monitor: runs on the falling edge, well away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_len = 0;
            end else begin
                checkOutput("ready_is_not_busy", {31'b0, ready}, {31'b0, ~busy});
                if (busy) busy_len++;
                if (done) begin
                    if (sb.size() == 0) begin
                        failNow("unexpected_done");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("product", p, e.p);
                        checkOutput("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                        checkOutput("latency", cycle - e.accept, 32'd16);
                        checkOutput("busy_cycles", busy_len, 32'd16);
                    end
                    busy_len = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a_in, input logic [15:0] b_in,
                                 input logic [31:0] exp_p, input logic exp_ovf,
                                 input bit track);
        exp_t e;
        for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
        if (!ready) failNow("ready_timeout");
        start = 1'b1;
        a     = a_in;
        b     = b_in;
        if (track) begin
            e.p      = exp_p;
            e.ovf    = exp_ovf;
            e.accept = cycle + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitResults();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failNow("result_timeout");
            sb.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, {31'b0, ready}, 32'd1);
        checkOutput({tag, "_busy"},  {31'b0, busy},  32'd0);
        checkOutput({tag, "_done"},  {31'b0, done},  32'd0);
        checkOutput({tag, "_p"},     p,              32'd0);
        checkOutput({tag, "_ovf"},   {31'b0, ovf},   32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'd3, 16'd5, 32'h0000_000F, 1'b0, 1'b1);
        waitResults();
        applyStimulus(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b1);
        waitResults();
        applyStimulus(16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 1'b1);
        waitResults();
        applyStimulus(16'h0100, 16'h0100, 32'h0001_0000, 1'b1, 1'b1);
        waitResults();

        // A start while busy must be ignored; a start in DONE chains directly.
        applyStimulus(16'd7, 16'd9, 32'h0000_003F, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("busy_mid_run", {31'b0, busy}, 32'd1);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0002;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) begin
            failNow("first_done_timeout");
        end else begin
            start    = 1'b1;
            a        = 16'h00FF;
            b        = 16'h0101;
            e.p      = 32'h0000_FFFF;
            e.ovf    = 1'b0;
            e.accept = cycle + 1;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
        waitResults();

        // With start held low the result must stay put and done stay low.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_p", p, 32'h0000_FFFF);
            checkOutput("hold_ovf", {31'b0, ovf}, 32'd0);
            checkOutput("hold_done", {31'b0, done}, 32'd0);
            checkOutput("hold_ready", {31'b0, ready}, 32'd1);
        end

        applyStimulus(16'hABCD, 16'h1234, 32'h0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_p_after", p, 32'd0);
        applyStimulus(16'd2, 16'h8000, 32'h0001_0000, 1'b1, 1'b1);
        waitResults();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
